// File: rtl/gf180mcu_fd_sc_mcu7t5v0__supmon_pkg.sv
// Shared encodings and widths for the supply-good monitor.
package gf180mcu_fd_sc_mcu7t5v0__supmon_pkg;

    // Monitor FSM state; the encoding is visible on the STATE port.
    typedef enum logic [1:0] {
        st_off   = 2'd0,
        st_qual  = 2'd1,
        st_good  = 2'd2,
        st_fault = 2'd3
    } state_t;

    // Width of the saturating dropout counter.
    localparam int gcnt_w = 8;

    // Width of the consecutive-low run counter; covers GLITCH_LIMIT up to 15.
    localparam int lc_w = 4;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__supmon_sync.sv
// Multi-flop synchronizer that brings the asynchronous rail-ok level into the clk domain.
module gf180mcu_fd_sc_mcu7t5v0__supmon_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the input through the flop chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__supmon.sv
// Supply-good monitor: qualifies the rail-ok level, drives a registered power-good,
// counts tolerated dropouts and latches a sticky fault on a sustained loss.
//
// state | meaning
// ------+---------------------------------------------------------------
// OFF   | rail not seen; waiting for the synced level to go high
// QUAL  | rail high; counting STABLE_CYCLES consecutive high samples
// GOOD  | power-good asserted; short lows are counted as glitches
// FAULT | sustained loss; held until acknowledged while the rail is low
module gf180mcu_fd_sc_mcu7t5v0__supmon
    import gf180mcu_fd_sc_mcu7t5v0__supmon_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int GLITCH_LIMIT  = 3
) (
`ifdef USE_POWER_PINS
    inout  wire               VDD,
    inout  wire               VSS,
`endif
    input  logic              CLK,
    input  logic              RST,
    input  logic              VDD_OK,
    input  logic              FAULT_ACK,
    output logic              PGOOD,
    output logic              FAULT,
    output logic [1:0]        STATE,
    output logic [gcnt_w-1:0] GLITCH_CNT
);

    // A single-cycle qualify window still needs one counter bit.
    localparam int QC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [QC_W-1:0] qc_last  = QC_W'(STABLE_CYCLES - 1);
    localparam logic [lc_w-1:0] lc_limit = lc_w'(GLITCH_LIMIT);

    logic              s;
    state_t            state, state_d;
    logic [QC_W-1:0]   qc, qc_d;
    logic [lc_w-1:0]   lc, lc_d, lc_inc;
    logic [gcnt_w-1:0] gcnt, gcnt_d;
    logic              pgood_q, fault_q;

    gf180mcu_fd_sc_mcu7t5v0__supmon_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(CLK),
        .rst(RST),
        .d  (VDD_OK),
        .q  (s)
    );

    assign lc_inc = lc + 1'b1;

    // Next-state and counter updates; every decision looks only at the synced level.
    always_comb begin
        state_d = state;
        qc_d    = qc;
        lc_d    = lc;
        gcnt_d  = gcnt;
        case (state)
            st_off: begin
                if (s) begin
                    state_d = st_qual;
                    qc_d    = '0;
                end
            end
            st_qual: begin
                if (!s) begin
                    state_d = st_off;
                    qc_d    = '0;
                end else if (qc == qc_last) begin
                    state_d = st_good;
                    lc_d    = '0;
                end else begin
                    qc_d = qc + 1'b1;
                end
            end
            st_good: begin
                if (!s) begin
                    if (lc_inc == lc_limit) begin
                        state_d = st_fault;
                        lc_d    = '0;
                    end else begin
                        lc_d = lc_inc;
                    end
                end else if (lc != '0) begin
                    // Rail came back before the limit: count the dropout, never wrap.
                    lc_d = '0;
                    if (gcnt != '1) begin
                        gcnt_d = gcnt + 1'b1;
                    end
                end
            end
            st_fault: begin
                // Acknowledge only takes effect once the rail is really down,
                // so a fault cannot be cleared while the comparator still says ok.
                if (FAULT_ACK && !s) begin
                    state_d = st_off;
                    gcnt_d  = '0;
                end
            end
            default: begin
                state_d = st_off;
            end
        endcase
    end

    // State, counters and outputs all update on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= st_off;
            qc      <= '0;
            lc      <= '0;
            gcnt    <= '0;
            pgood_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_d;
            qc      <= qc_d;
            lc      <= lc_d;
            gcnt    <= gcnt_d;
            pgood_q <= (state_d == st_good);
            fault_q <= (state_d == st_fault);
        end
    end

    assign PGOOD      = pgood_q;
    assign FAULT      = fault_q;
    assign STATE      = state;
    assign GLITCH_CNT = gcnt;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__supmon.sv
// Directed, table-driven bench for the supply-good monitor (default parameters).
module tb_gf180mcu_fd_sc_mcu7t5v0__supmon;

    logic       clk;
    logic       rst;
    logic       vdd_ok;
    logic       fault_ack;
    logic       pgood;
    logic       fault;
    logic [1:0] state;
    logic [7:0] gcnt;
`ifdef USE_POWER_PINS
    wire        vdd;
    wire        vss;
`endif

    int checks = 0;
    int errors = 0;

    gf180mcu_fd_sc_mcu7t5v0__supmon dut (
`ifdef USE_POWER_PINS
        .VDD       (vdd),
        .VSS       (vss),
`endif
        .CLK       (clk),
        .RST       (rst),
        .VDD_OK    (vdd_ok),
        .FAULT_ACK (fault_ack),
        .PGOOD     (pgood),
        .FAULT     (fault),
        .STATE     (state),
        .GLITCH_CNT(gcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vdd;
        logic       ack;
        int         cycles;
        logic [1:0] st;
        logic       pg;
        logic       flt;
        logic [7:0] gc;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [1:0] st, input logic pg,
                             input logic flt, input logic [7:0] gc);
        check({name, " STATE"}, {6'd0, state}, {6'd0, st});
        check({name, " PGOOD"}, {7'd0, pgood}, {7'd0, pg});
        check({name, " FAULT"}, {7'd0, fault}, {7'd0, flt});
        check({name, " GLITCH_CNT"}, gcnt, gc);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        vdd_ok    = 1'b0;
        fault_ack = 1'b0;
        ticks(3);
        rst = 1'b0;
    endtask

    // Counts edges from the moment vdd_ok goes high; PGOOD must rise on edge 19 exactly.
    task automatic qualify(input string name);
        vdd_ok = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 18) check({name, " pgood@18"}, {7'd0, pgood}, 8'd0);
            if (k == 19) check({name, " pgood@19"}, {7'd0, pgood}, 8'd1);
        end
        check({name, " state"}, {6'd0, state}, 8'd2);
    endtask

    initial begin
        rst       = 1'b1;
        vdd_ok    = 1'b0;
        fault_ack = 1'b0;

        //            rst   vdd   ack   cyc st     pg    flt   gc
        tbl[0] = '{1'b1, 1'b0, 1'b0,  3, 2'd0, 1'b0, 1'b0, 8'd0}; // reset
        tbl[1] = '{1'b0, 1'b0, 1'b1,  4, 2'd0, 1'b0, 1'b0, 8'd0}; // ack in OFF
        tbl[2] = '{1'b0, 1'b1, 1'b0, 19, 2'd2, 1'b1, 1'b0, 8'd0}; // qualify
        tbl[3] = '{1'b0, 1'b1, 1'b1,  5, 2'd2, 1'b1, 1'b0, 8'd0}; // ack in GOOD
        tbl[4] = '{1'b0, 1'b0, 1'b0,  2, 2'd2, 1'b1, 1'b0, 8'd0}; // 2-cycle dropout
        tbl[5] = '{1'b0, 1'b1, 1'b0,  4, 2'd2, 1'b1, 1'b0, 8'd1}; // tolerated
        tbl[6] = '{1'b0, 1'b0, 1'b0,  5, 2'd3, 1'b0, 1'b1, 8'd1}; // sustained loss
        tbl[7] = '{1'b0, 1'b1, 1'b0,  3, 2'd3, 1'b0, 1'b1, 8'd1}; // rail back, fault sticky
        tbl[8] = '{1'b0, 1'b1, 1'b1,  4, 2'd3, 1'b0, 1'b1, 8'd1}; // ack while high ignored
        tbl[9] = '{1'b0, 1'b0, 1'b1,  4, 2'd0, 1'b0, 1'b0, 8'd0}; // ack while low clears

        for (int i = 0; i < 10; i++) begin
            rst       = tbl[i].rst;
            vdd_ok    = tbl[i].vdd;
            fault_ack = tbl[i].ack;
            ticks(tbl[i].cycles);
            check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].pg, tbl[i].flt, tbl[i].gc);
        end
        fault_ack = 1'b0;

        // Power-up latency, edge by edge.
        do_reset();
        check_all("reset", 2'd0, 1'b0, 1'b0, 8'd0);
        vdd_ok = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            check($sformatf("pwrup pgood@%0d", k), {7'd0, pgood}, (k == 19) ? 8'd1 : 8'd0);
            if (k == 2) check("pwrup state@2", {6'd0, state}, 8'd0);
            if (k == 3) check("pwrup state@3", {6'd0, state}, 8'd1);
        end
        check_all("pwrup done", 2'd2, 1'b1, 1'b0, 8'd0);

        // Repeated tolerated glitches saturate the counter.
        begin
            logic pg_dropped;
            pg_dropped = 1'b0;
            for (int i = 0; i < 300; i++) begin
                vdd_ok = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    tick();
                    if (pgood !== 1'b1) pg_dropped = 1'b1;
                end
                vdd_ok = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    tick();
                    if (pgood !== 1'b1) pg_dropped = 1'b1;
                end
                check($sformatf("glitch cnt #%0d", i + 1), gcnt, (i < 255) ? 8'(i + 1) : 8'd255);
            end
            check("glitch pgood held", {7'd0, pg_dropped}, 8'd0);
        end

        // Sustained loss: PGOOD falls and FAULT rises on edge 5 after the fall.
        vdd_ok = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("loss pgood@%0d", k), {7'd0, pgood}, (k < 5) ? 8'd1 : 8'd0);
            check($sformatf("loss fault@%0d", k), {7'd0, fault}, (k < 5) ? 8'd0 : 8'd1);
        end
        check_all("loss done", 2'd3, 1'b0, 1'b1, 8'd255);

        // Aborted qualify: state drops to OFF then re-enters QUAL; full latency from second rise.
        do_reset();
        vdd_ok = 1'b1;
        ticks(10);
        vdd_ok = 1'b0;
        tick();
        vdd_ok = 1'b1;
        for (int k = 12; k <= 30; k++) begin
            tick();
            if (k == 12) check("abort state@12", {6'd0, state}, 8'd1);
            if (k == 13) check("abort state@13", {6'd0, state}, 8'd0);
            if (k == 14) check("abort state@14", {6'd0, state}, 8'd1);
            if (k == 29) check("abort pgood@29", {7'd0, pgood}, 8'd0);
            if (k == 30) check("abort pgood@30", {7'd0, pgood}, 8'd1);
        end

        // Reset in the middle of QUAL (qc=7 after edge 10).
        do_reset();
        vdd_ok = 1'b1;
        ticks(10);
        check("midqual state", {6'd0, state}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all("midqual rst", 2'd0, 1'b0, 1'b0, 8'd0);
        qualify("midqual requal");

        // Reset while in FAULT with a non-zero glitch count.
        vdd_ok = 1'b0;
        ticks(2);
        vdd_ok = 1'b1;
        ticks(4);
        check("midfault gcnt", gcnt, 8'd1);
        vdd_ok = 1'b0;
        ticks(6);
        check_all("midfault pre", 2'd3, 1'b0, 1'b1, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all("midfault rst", 2'd0, 1'b0, 1'b0, 8'd0);
        qualify("midfault requal");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
